gated_square_oscillator_bank: RTL and testbench

GATED_SQUARE_OSCILLATOR_BANK -- requirements
Module: gated_square_oscillator_bank

---
 rtl/discrete_pkg.sv | 26 ++
 rtl/square_oscillator_channel.sv | 79 +++++++
 rtl/gated_square_oscillator_bank.sv | 65 ++++++
 tb/tb_gated_square_oscillator_bank.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/discrete_pkg.sv
// Shared signal-domain definitions for the discrete audio blocks: signal width,
// saturation limits and a voltage-to-signal conversion used for parameter defaults.
package discrete_pkg;

    localparam int SIG_W = 16;
    localparam logic signed [SIG_W-1:0] SIG_MAX = 16'sh7FFF;
    localparam logic signed [SIG_W-1:0] SIG_MIN = 16'sh8000;

    // Rounded (mv / vcc_mv) * 2^frac_w, so 5 V at 12 V VCC with 14 fraction bits gives 6827.
    function automatic logic signed [SIG_W-1:0] volts_to_signal(input int mv, input int vcc_mv,
                                                                input int frac_w);
        longint scaled;
        scaled = ((longint'(mv) <<< frac_w) + longint'(vcc_mv / 2)) / longint'(vcc_mv);
        return scaled[SIG_W-1:0];
    endfunction

    function automatic logic signed [SIG_W-1:0] saturate(input logic signed [31:0] value);
        if (value > 32'sd32767) begin
            return SIG_MAX;
        end else if (value < -32'sd32768) begin
            return SIG_MIN;
        end
        return value[SIG_W-1:0];
    endfunction

endpackage

// File: rtl/square_oscillator_channel.sv
// One gated square oscillator: period counter, phase-coherent gating, audio-rate sampling
// and optional slew limiting (compiled in with GATED_SQUARE_OSCILLATOR_SLEW_EN).
module square_oscillator_channel
    import discrete_pkg::*;
#(
    parameter int                      COUNTER_WIDTH = 24,
    parameter logic signed [SIG_W-1:0] HIGH_LEVEL    = 16'sd6827,
    parameter int                      SLEW_STEP     = 28
) (
    input  logic                     clk,
    input  logic                     I_RST,
    input  logic                     audio_clk_en,
    input  logic                     enable,
    input  logic [COUNTER_WIDTH-1:0] period,
    input  logic [COUNTER_WIDTH-1:0] high_count,
    output logic signed [SIG_W-1:0]  out
);

    logic [COUNTER_WIDTH-1:0] count_reg, count_next;
    logic [COUNTER_WIDTH-1:0] eff_period;
    logic                     raw_level;
    logic signed [SIG_W-1:0]  unfilt_reg, unfilt_next;

    // The wrap test uses >= so a period shrunk below the current count cannot lock up.
    always_comb begin
        eff_period  = (period < COUNTER_WIDTH'(2)) ? COUNTER_WIDTH'(2) : period;
        raw_level   = enable && (count_reg < high_count);
        unfilt_next = raw_level ? HIGH_LEVEL : '0;
        count_next  = '0;
        if (enable && (count_reg < eff_period - COUNTER_WIDTH'(1))) begin
            count_next = count_reg + COUNTER_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (I_RST) begin
            count_reg  <= '0;
            unfilt_reg <= '0;
        end else begin
            count_reg <= count_next;
            if (audio_clk_en) begin
                unfilt_reg <= unfilt_next;
            end
        end
    end

`ifdef GATED_SQUARE_OSCILLATOR_SLEW_EN
    localparam logic signed [SIG_W:0] STEP = (SIG_W+1)'(SLEW_STEP);

    logic signed [SIG_W-1:0] out_reg, out_next;
    logic signed [SIG_W:0]   diff;

    // Chases the sample registered on the previous strobe, one sample behind the raw level.
    always_comb begin
        diff     = (SIG_W+1)'(unfilt_reg) - (SIG_W+1)'(out_reg);
        out_next = unfilt_reg;
        if (diff > STEP) begin
            out_next = out_reg + STEP[SIG_W-1:0];
        end else if (diff < -STEP) begin
            out_next = out_reg - STEP[SIG_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (I_RST) begin
            out_reg <= '0;
        end else if (audio_clk_en) begin
            out_reg <= out_next;
        end
    end

    assign out = out_reg;
`else
    logic unused_slew;
    assign unused_slew = ^SLEW_STEP;
    assign out         = unfilt_reg;
`endif

endmodule

// File: rtl/gated_square_oscillator_bank.sv
// Bank of gated square oscillators with a saturating mixer.
// Define GATED_SQUARE_OSCILLATOR_SLEW_EN to compile in per-channel slew limiting.
module gated_square_oscillator_bank
    import discrete_pkg::*;
#(
    parameter int                      CHANNELS              = 2,
    parameter int                      SIGNAL_FRACTION_WIDTH = 14,
    parameter int                      COUNTER_WIDTH         = 24,
    parameter logic signed [SIG_W-1:0] HIGH_LEVEL            = volts_to_signal(5000, 12000, SIGNAL_FRACTION_WIDTH),
    parameter int                      SLEW_STEP             = 28
) (
    input  logic                              clk,
    input  logic                              I_RST,
    input  logic                              audio_clk_en,
    input  logic [CHANNELS-1:0]               enable,
    input  logic [CHANNELS*COUNTER_WIDTH-1:0] period,
    input  logic [CHANNELS*COUNTER_WIDTH-1:0] high_count,
    output logic [CHANNELS*SIG_W-1:0]         out,
    output logic signed [SIG_W-1:0]           mix_out
);

    localparam int SUM_W = SIG_W + $clog2(CHANNELS);

    logic signed [SIG_W-1:0] ch_out [CHANNELS];
    logic signed [SUM_W-1:0] mix_sum;
    logic signed [SIG_W-1:0] mix_reg;

    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_channel
            square_oscillator_channel #(
                .COUNTER_WIDTH (COUNTER_WIDTH),
                .HIGH_LEVEL    (HIGH_LEVEL),
                .SLEW_STEP     (SLEW_STEP)
            ) u_channel (
                .clk          (clk),
                .I_RST        (I_RST),
                .audio_clk_en (audio_clk_en),
                .enable       (enable[gi]),
                .period       (period[gi*COUNTER_WIDTH +: COUNTER_WIDTH]),
                .high_count   (high_count[gi*COUNTER_WIDTH +: COUNTER_WIDTH]),
                .out          (ch_out[gi])
            );
            assign out[gi*SIG_W +: SIG_W] = ch_out[gi];
        end
    endgenerate

    always_comb begin
        mix_sum = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            mix_sum = mix_sum + SUM_W'(ch_out[i]);
        end
    end

    // Mixes the outputs as they stand before this strobe, so the mix lags out by one sample.
    always_ff @(posedge clk) begin
        if (I_RST) begin
            mix_reg <= '0;
        end else if (audio_clk_en) begin
            mix_reg <= saturate(32'(mix_sum));
        end
    end

    assign mix_out = mix_reg;

endmodule

// File: tb/tb_gated_square_oscillator_bank.sv
// Directed self-checking bench for gated_square_oscillator_bank (8 channels).
`timescale 1ns/1ps
module tb_gated_square_oscillator_bank;

    localparam int CH = 8;
    localparam int CW = 24;
    localparam logic signed [15:0] HI = 16'sd6827;

    logic                    clk = 1'b0;
    logic                    I_RST;
    logic                    audio_clk_en;
    logic [CH-1:0]           enable;
    logic [CH*CW-1:0]        period;
    logic [CH*CW-1:0]        high_count;
    logic [CH*16-1:0]        out;
    logic signed [15:0]      mix_out;
    logic signed [15:0]      out0;

    int checks = 0;
    int errors = 0;

    // Reference output of channel 0
    logic signed [15:0] exp_out;
    logic signed [15:0] exp_unfilt;

    always #5 clk = ~clk;
    assign out0 = out[15:0];

    gated_square_oscillator_bank #(
        .CHANNELS              (CH),
        .SIGNAL_FRACTION_WIDTH (14),
        .COUNTER_WIDTH         (CW),
        .HIGH_LEVEL            (HI),
        .SLEW_STEP             (28)
    ) dut (
        .clk          (clk),
        .I_RST        (I_RST),
        .audio_clk_en (audio_clk_en),
        .enable       (enable),
        .period       (period),
        .high_count   (high_count),
        .out          (out),
        .mix_out      (mix_out)
    );

    task automatic set_ch(input int ch, input int p, input int h);
        period[ch*CW +: CW]     = CW'(p);
        high_count[ch*CW +: CW] = CW'(h);
    endtask

    // Advances one clock; raw is the level channel 0 shows in the cycle before the edge.
    task automatic step(input bit raw, input bit aen);
        logic signed [16:0] d;
        audio_clk_en = aen;
        if (aen) begin
`ifdef GATED_SQUARE_OSCILLATOR_SLEW_EN
            d = 17'(exp_unfilt) - 17'(exp_out);
            if (d > 17'sd28)       exp_out = exp_out + 16'sd28;
            else if (d < -17'sd28) exp_out = exp_out - 16'sd28;
            else                   exp_out = exp_unfilt;
`endif
            exp_unfilt = raw ? HI : 16'sd0;
`ifndef GATED_SQUARE_OSCILLATOR_SLEW_EN
            exp_out = exp_unfilt;
`endif
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        I_RST        = 1'b1;
        audio_clk_en = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        I_RST      = 1'b0;
        exp_out    = '0;
        exp_unfilt = '0;
    endtask

    task automatic test_reset();
        enable = '1;
        for (int i = 0; i < CH; i++) set_ch(i, 10, 20);
        do_reset();
        for (int i = 0; i < CH; i++) begin
            checks++;
            $display("reset ch=%0d out=%0d", i, $signed(out[i*16 +: 16]));
            if (out[i*16 +: 16] !== 16'd0) begin
                errors++;
                $display("FAIL reset_out ch=%0d got=%0d want=0", i, $signed(out[i*16 +: 16]));
            end
        end
        checks++;
        $display("reset mix=%0d", mix_out);
        if (mix_out !== 16'sd0) begin
            errors++;
            $display("FAIL reset_mix got=%0d want=0", mix_out);
        end
    endtask

    task automatic test_basic();
        enable = 8'h01;
        set_ch(0, 10, 5);
        do_reset();
        for (int k = 0; k < 37; k++) begin
            if (k >= 20 && k < 27) step(1'b0, 1'b0);
            else                   step((k % 10) < 5, 1'b1);
            checks++;
            $display("basic k=%0d out=%0d", k, out0);
            if (out0 !== exp_out) begin
                errors++;
                $display("FAIL basic k=%0d got=%0d want=%0d", k, out0, exp_out);
            end
        end
    endtask

    task automatic test_gating();
        enable = 8'h01;
        set_ch(0, 10, 5);
        do_reset();
        for (int k = 0; k < 16; k++) begin
            if (k == 3)  enable = 8'h00;
            if (k == 6)  enable = 8'h01;
            if (k >= 3 && k < 6) step(1'b0, 1'b1);
            else if (k < 3)      step(1'b1, 1'b1);
            else                 step(((k - 6) % 10) < 5, 1'b1);
            checks++;
            $display("gating k=%0d en=%0d out=%0d", k, enable[0], out0);
            if (out0 !== exp_out) begin
                errors++;
                $display("FAIL gating k=%0d got=%0d want=%0d", k, out0, exp_out);
            end
        end
    endtask

    task automatic test_constant();
        enable = 8'h01;
        set_ch(0, 10, 0);
        do_reset();
        for (int k = 0; k < 44; k++) begin
            if (k == 12) set_ch(0, 10, 20);
            if (k == 24 || k == 34) enable = 8'h00;
            if (k == 25) begin set_ch(0, 1, 1); enable = 8'h01; end
            if (k == 35) begin set_ch(0, 0, 1); enable = 8'h01; end
            if (k < 12)                 step(1'b0, 1'b1);
            else if (k < 24)            step(1'b1, 1'b1);
            else if (k == 24 || k == 34) step(1'b0, 1'b1);
            else if (k < 34)            step(((k - 25) % 2) == 0, 1'b1);
            else                        step(((k - 35) % 2) == 0, 1'b1);
            checks++;
            $display("constant k=%0d out=%0d", k, out0);
            if (out0 !== exp_out) begin
                errors++;
                $display("FAIL constant k=%0d got=%0d want=%0d", k, out0, exp_out);
            end
        end
    endtask

    task automatic test_period_change();
        enable = 8'h01;
        set_ch(0, 20, 2);
        do_reset();
        for (int k = 0; k < 21; k++) begin
            if (k == 8) set_ch(0, 5, 2);
            if (k < 8)       step(k < 2, 1'b1);
            else if (k == 8) step(1'b0, 1'b1);
            else             step(((k - 9) % 5) < 2, 1'b1);
            checks++;
            $display("period_change k=%0d out=%0d", k, out0);
            if (out0 !== exp_out) begin
                errors++;
                $display("FAIL period_change k=%0d got=%0d want=%0d", k, out0, exp_out);
            end
        end
    endtask

`ifdef GATED_SQUARE_OSCILLATOR_SLEW_EN
    task automatic test_slew();
        enable = 8'h01;
        set_ch(0, 10, 20);
        do_reset();
        for (int n = 1; n <= 246; n++) begin
            step(1'b1, 1'b1);
            checks++;
            if (out0 !== exp_out) begin
                errors++;
                $display("FAIL slew n=%0d got=%0d want=%0d", n, out0, exp_out);
            end
            if (n == 2 || n == 244 || n == 245) begin
                $display("slew n=%0d out=%0d", n, out0);
                checks++;
                if (out0 !== ((n == 2) ? 16'sd28 : (n == 244) ? 16'sd6804 : 16'sd6827)) begin
                    errors++;
                    $display("FAIL slew_point n=%0d got=%0d", n, out0);
                end
            end
        end
    endtask
`endif

    task automatic test_mix();
        enable = '1;
        for (int i = 0; i < CH; i++) set_ch(i, 10, 20);
        do_reset();
`ifndef GATED_SQUARE_OSCILLATOR_SLEW_EN
        step(1'b1, 1'b1);
        checks++;
        $display("mix_lag out0=%0d mix=%0d", out0, mix_out);
        if (mix_out !== 16'sd0) begin
            errors++;
            $display("FAIL mix_lag got=%0d want=0", mix_out);
        end
`endif
        for (int n = 0; n < 260; n++) step(1'b1, 1'b1);
        for (int i = 0; i < CH; i++) begin
            checks++;
            $display("mix_full ch=%0d out=%0d", i, $signed(out[i*16 +: 16]));
            if (out[i*16 +: 16] !== HI) begin
                errors++;
                $display("FAIL mix_full_out ch=%0d got=%0d want=6827", i, $signed(out[i*16 +: 16]));
            end
        end
        checks++;
        $display("mix_sat mix=%0d", mix_out);
        if (mix_out !== 16'sd32767) begin
            errors++;
            $display("FAIL mix_sat got=%0d want=32767", mix_out);
        end
        // Reset in the middle of saturated operation clears everything at one edge.
        I_RST = 1'b1;
        @(posedge clk); #1;
        I_RST = 1'b0;
        exp_out = '0; exp_unfilt = '0;
        for (int i = 0; i < CH; i++) begin
            checks++;
            if (out[i*16 +: 16] !== 16'd0) begin
                errors++;
                $display("FAIL mix_reset_out ch=%0d got=%0d want=0", i, $signed(out[i*16 +: 16]));
            end
        end
        checks++;
        $display("mix_reset mix=%0d", mix_out);
        if (mix_out !== 16'sd0) begin
            errors++;
            $display("FAIL mix_reset_mix got=%0d want=0", mix_out);
        end
        enable = 8'h0F;
        for (int n = 0; n < 260; n++) step(1'b1, 1'b1);
        for (int i = 0; i < CH; i++) begin
            checks++;
            if (out[i*16 +: 16] !== ((i < 4) ? HI : 16'sd0)) begin
                errors++;
                $display("FAIL mix_half_out ch=%0d got=%0d", i, $signed(out[i*16 +: 16]));
            end
        end
        checks++;
        $display("mix_half mix=%0d", mix_out);
        if (mix_out !== 16'sd27308) begin
            errors++;
            $display("FAIL mix_half got=%0d want=27308", mix_out);
        end
    endtask

    initial begin
        I_RST        = 1'b1;
        audio_clk_en = 1'b0;
        enable       = '0;
        period       = '0;
        high_count   = '0;
        exp_out      = '0;
        exp_unfilt   = '0;
        test_reset();
        test_basic();
        test_gating();
        test_constant();
        test_period_change();
`ifdef GATED_SQUARE_OSCILLATOR_SLEW_EN
        test_slew();
`endif
        test_mix();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
